vga_timing_ctrl: RTL and testbench

Sequences the VGA pixel datapath from the 100 MHz master clock. It produces a single-cycle pixel-tick enable, replacing the divided-clock approach with a clock enable. It also runs the horizontal and vertical scan counters and generates hsync, vsync, video_on and pixel coordinates for the RTC display renderer. All logic is in the master clock domain.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_ctrl_pixel_tick_gen.sv | 41 ++++
 rtl/vga_timing_ctrl.sv | 130 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and decode helpers.
// The optional frame counter is enabled by defining VGA_FRAME_CNT_EN.
package vga_pkg;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 8;
  localparam int DEF_DIV     = 4;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Inclusive window test used for both sync decoders.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_pixel_tick_gen.sv
// DIV-cycle prescaler producing a one-clk pixel enable; freezes when enable is low.
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic p_tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 1 || DIV > 16) begin : g_bad_div
      $error("pixel_tick_gen: DIV must be in 1..16");
    end
  endgenerate

  logic [CW-1:0] tick_cnt_q;
  logic [CW-1:0] tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (enable_i) begin
      tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Gated by reset so a DIV=1 build stays quiet while held in reset.
  assign p_tick_o = rst_ni && enable_i && (tick_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing on the master clock: pixel enable, scan counters, syncs, video_on.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               p_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_end,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL    = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_LO  = H_DISPLAY + H_FP;
  localparam int H_SYNC_HI  = H_SYNC_LO + H_SYNC - 1;
  localparam int V_SYNC_LO  = V_DISPLAY + V_FP;
  localparam int V_SYNC_HI  = V_SYNC_LO + V_SYNC - 1;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  generate
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
      $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must each be <= 1024");
    end
  endgenerate

  pixel_tick_gen #(
    .DIV(DIV)
  ) u_pixel_tick_gen (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .enable_i (enable),
    .p_tick_o (p_tick)
  );

  logic [COORD_W-1:0] pixel_x_q, pixel_x_d;
  logic [COORD_W-1:0] pixel_y_q, pixel_y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               frame_start_q, frame_start_d;

  // Syncs decode the next coordinates so they land on the same edge as pixel_x/y.
  always_comb begin
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (p_tick) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = '0;
        pixel_y_d = (pixel_y_q == V_LAST) ? '0 : pixel_y_q + COORD_W'(1);
      end else begin
        pixel_x_d = pixel_x_q + COORD_W'(1);
      end
    end
    hsync_d       = !in_window(pixel_x_d, H_SYNC_LO, H_SYNC_HI);
    vsync_d       = !in_window(pixel_y_d, V_SYNC_LO, V_SYNC_HI);
    video_on_d    = (int'(pixel_x_d) < H_DISPLAY) && (int'(pixel_y_d) < V_DISPLAY);
    frame_start_d = p_tick && (pixel_x_q == H_LAST) && (pixel_y_q == V_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_end    = p_tick && (pixel_x_q == H_LAST);
  // A frozen chain reports no frame start even if the wrap happened just before.
  assign frame_start = frame_start_q && enable;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default 640x480 DIV=4 instance and a tiny DIV=1 instance
// against a position/phase reference model. Honours VGA_FRAME_CNT_EN when defined.
module tb_vga_timing_ctrl;

  localparam int W = 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic en0, en1;

  logic       p_tick0, hsync0, vsync0, video_on0, line_end0, frame_start0;
  logic [9:0] pixel_x0, pixel_y0;
  logic       p_tick1, hsync1, vsync1, video_on1, line_end1, frame_start1;
  logic [9:0] pixel_x1, pixel_y1;
  logic [7:0] fc0, fc1;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt0, frame_cnt1;
  assign fc0 = frame_cnt0;
  assign fc1 = frame_cnt1;
`else
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
`endif

  vga_timing_ctrl u_dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (en0),
    .p_tick      (p_tick0),
    .hsync       (hsync0),
    .vsync       (vsync0),
    .video_on    (video_on0),
    .pixel_x     (pixel_x0),
    .pixel_y     (pixel_y0),
    .line_end    (line_end0),
    .frame_start (frame_start0)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt0)
`endif
  );

  vga_timing_ctrl #(
    .DIV(1), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (en1),
    .p_tick      (p_tick1),
    .hsync       (hsync1),
    .vsync       (vsync1),
    .video_on    (video_on1),
    .pixel_x     (pixel_x1),
    .pixel_y     (pixel_y1),
    .line_end    (line_end1),
    .frame_start (frame_start1)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt1)
`endif
  );

  logic [W-1:0] act0, act1;
  assign act0 = {p_tick0, hsync0, vsync0, video_on0, line_end0, frame_start0,
                 pixel_x0, pixel_y0, fc0};
  assign act1 = {p_tick1, hsync1, vsync1, video_on1, line_end1, frame_start1,
                 pixel_x1, pixel_y1, fc1};

  // ---------------- reference model ----------------
  // State is a linear pixel position within the frame plus a prescaler phase.
  int m_div[2] = '{4, 1};
  int m_hd[2]  = '{640, 8};
  int m_hfp[2] = '{16, 2};
  int m_hs[2]  = '{96, 3};
  int m_hbp[2] = '{48, 3};
  int m_vd[2]  = '{480, 4};
  int m_vfp[2] = '{10, 1};
  int m_vs[2]  = '{2, 2};
  int m_vbp[2] = '{33, 2};

  int phase[2];
  int pos[2];
  int fcnt[2];
  bit fs[2];

  function automatic int htot(int k);
    return m_hd[k] + m_hfp[k] + m_hs[k] + m_hbp[k];
  endfunction

  function automatic int ftot(int k);
    return htot(k) * (m_vd[k] + m_vfp[k] + m_vs[k] + m_vbp[k]);
  endfunction

  function automatic logic [W-1:0] exp_vec(int k, bit e, bit r);
    int x, y, hlo, vlo;
    bit tick, hs_n, vs_n, von, le, fso;
    logic [7:0] fc;
    x    = pos[k] % htot(k);
    y    = pos[k] / htot(k);
    hlo  = m_hd[k] + m_hfp[k];
    vlo  = m_vd[k] + m_vfp[k];
    tick = r && e && (phase[k] == m_div[k] - 1);
    hs_n = !(x >= hlo && x < hlo + m_hs[k]);
    vs_n = !(y >= vlo && y < vlo + m_vs[k]);
    von  = (x < m_hd[k]) && (y < m_vd[k]);
    le   = tick && (x == htot(k) - 1);
    fso  = fs[k] && e;
`ifdef VGA_FRAME_CNT_EN
    fc = 8'(fcnt[k]);
`else
    fc = 8'd0;
`endif
    return {tick, hs_n, vs_n, von, le, fso, 10'(x), 10'(y), fc};
  endfunction

  task automatic model_reset(int k);
    phase[k] = 0;
    pos[k]   = 0;
    fcnt[k]  = 0;
    fs[k]    = 1'b0;
  endtask

  task automatic model_step(int k, bit e, bit r);
    bit tick, nfs;
    if (!r) return;
    tick = e && (phase[k] == m_div[k] - 1);
    if (fs[k] && e) fcnt[k] = (fcnt[k] + 1) % 256;
    nfs = tick && (pos[k] == ftot(k) - 1);
    if (tick) pos[k] = (pos[k] + 1) % ftot(k);
    if (e) phase[k] = (phase[k] + 1) % m_div[k];
    fs[k] = nfs;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int vectors     = 0;
  int miscompares = 0;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        vectors++;
        if (act0 !== e) begin
          miscompares++;
          $display("FAIL dut0_outputs t=%0t: got %h want %h", $time, act0, e);
        end
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        vectors++;
        if (act1 !== e) begin
          miscompares++;
          $display("FAIL dut1_outputs t=%0t: got %h want %h", $time, act1, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic bit rand_en(int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic cycle(input bit e0, input bit e1, input bit r);
    bit was_up;
    @(posedge clk);
    model_step(0, en0, reset_n);
    model_step(1, en1, reset_n);
    #1;
    was_up  = reset_n;
    en0     = e0;
    en1     = e1;
    reset_n = r;
    if (!r) begin
      model_reset(0);
      model_reset(1);
    end
    exp_q0.push_back(exp_vec(0, e0, r));
    exp_q1.push_back(exp_vec(1, e1, r));
    if (was_up && !r) begin
      #1;
      vectors++;
      if (hsync0 !== 1'b1 || pixel_x0 !== 10'd0) begin
        miscompares++;
        $display("FAIL async_reset: hsync=%b pixel_x=%0d, want hsync=1 pixel_x=0",
                 hsync0, pixel_x0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en0     = 1'b0;
    en1     = 1'b0;
    model_reset(0);
    model_reset(1);

    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Free-running: two full lines on the default instance.
    repeat (6400) cycle(1'b1, 1'b1, 1'b1);

    // Freeze at pixel_x=300 of line 2 for 37 clks, then resume.
    for (int i = 0; i < 20000 && pos[0] != 1900; i++) cycle(1'b1, 1'b1, 1'b1);
    repeat (37) cycle(1'b0, 1'b1, 1'b1);
    repeat (4000) cycle(1'b1, 1'b1, 1'b1);

    // Randomised enable on both instances; the small one wraps frame_cnt here.
    repeat (36000) cycle(rand_en(85), rand_en(90), 1'b1);

    // Asynchronous reset in the middle of hsync.
    for (int i = 0; i < 20000 && (pos[0] % 800) != 700; i++) cycle(1'b1, rand_en(90), 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);

    repeat (12000) cycle(rand_en(85), rand_en(90), 1'b1);

    // Drain and report.
    repeat (2) @(negedge clk);
    #1;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected entries left, want 0/0",
               exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
